// File: rtl/ex_stage_if.sv
// Decode-to-execute handshake bundle: instruction/operand channel in, result channel out.
// The slave modport is the execute stage; the master modport is whatever drives it.
interface ex_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic            use_imm;
  logic [3:0]      alu_ctrl;
  logic [4:0]      rd_idx;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            branch;
  logic            jal;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] store_data;
  logic [4:0]      rd_idx_o;
  logic            reg_write_o;
  logic            mem_read_o;
  logic            mem_write_o;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;

  modport slave (
    input  in_valid, pc, rs1_data, rs2_data, imm, use_imm, alu_ctrl, rd_idx,
           reg_write, mem_read, mem_write, branch, jal, out_ready,
    output in_ready, out_valid, alu_result, store_data, rd_idx_o, reg_write_o,
           mem_read_o, mem_write_o, branch_taken, branch_target
  );

  modport master (
    output in_valid, pc, rs1_data, rs2_data, imm, use_imm, alu_ctrl, rd_idx,
           reg_write, mem_read, mem_write, branch, jal, out_ready,
    input  in_ready, out_valid, alu_result, store_data, rd_idx_o, reg_write_o,
           mem_read_o, mem_write_o, branch_taken, branch_target
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle base ALU ops plus lane-serial MatMul (dot product) and MPOOL,
// feeding one output register that holds its entry under backpressure.
module ex_stage #(
  parameter int XLEN   = 32,
  parameter int LANE_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  ex_stage_if.slave  bus
);
  localparam int NLANES = XLEN / LANE_W;
  localparam int CNT_W  = $clog2(NLANES);

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_AND    = 4'h2,
    OP_OR     = 4'h3,
    OP_XOR    = 4'h4,
    OP_RELU   = 4'h8,
    OP_MATMUL = 4'h9,
    OP_VADD   = 4'hA,
    OP_MPOOL  = 4'hB
  } op_e;

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] branch_target;
    logic [4:0]      rd_idx;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch_taken;
  } entry_t;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic             pool_q;
  logic             pend_jal;
  entry_t           pend_q;
  entry_t           out_q;
  logic             out_valid_q;

  logic                     accept;
  logic                     is_multi;
  logic [XLEN-1:0]          opb;
  logic [XLEN-1:0]          base_res;
  logic [XLEN-1:0]          lane0_x;
  entry_t                   new_entry;
  entry_t                   done_entry;
  logic signed [LANE_W-1:0] lane_a;
  logic signed [LANE_W-1:0] lane_b;
  logic signed [2*LANE_W-1:0] prod;
  logic [XLEN-1:0]          lane_a_x;
  logic [XLEN-1:0]          prod_x;
  logic [XLEN-1:0]          step;

  // NOTE: in_ready is combinational on out_ready so a drain and a new accept can share one edge.
  assign bus.in_ready = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_multi     = (bus.alu_ctrl == OP_MATMUL) || (bus.alu_ctrl == OP_MPOOL);
  assign lane0_x      = {{(XLEN-LANE_W){bus.rs1_data[LANE_W-1]}}, bus.rs1_data[LANE_W-1:0]};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    opb      = bus.use_imm ? bus.imm : bus.rs2_data;
    base_res = '0;
    case (bus.alu_ctrl)
      OP_ADD:  base_res = bus.rs1_data + opb;
      OP_SUB:  base_res = bus.rs1_data - opb;
      OP_AND:  base_res = bus.rs1_data & opb;
      OP_OR:   base_res = bus.rs1_data | opb;
      OP_XOR:  base_res = bus.rs1_data ^ opb;
      OP_RELU: base_res = bus.rs1_data[XLEN-1] ? '0 : bus.rs1_data;
      OP_VADD: begin
        for (int i = 0; i < NLANES; i++) begin
          base_res[i*LANE_W +: LANE_W] = bus.rs1_data[i*LANE_W +: LANE_W]
                                       + bus.rs2_data[i*LANE_W +: LANE_W];
        end
      end
      default: base_res = '0;
    endcase

    new_entry.alu_result    = bus.jal ? bus.pc + XLEN'(4) : base_res;
    new_entry.store_data    = bus.rs2_data;
    new_entry.branch_target = bus.pc + bus.imm;
    new_entry.rd_idx        = bus.rd_idx;
    new_entry.reg_write     = bus.reg_write;
    new_entry.mem_read      = bus.mem_read;
    new_entry.mem_write     = bus.mem_write;
    new_entry.branch_taken  = bus.jal || (bus.branch && (bus.rs1_data == bus.rs2_data));
  end

  // One lane of the iterative ops: signed multiply-accumulate or signed running max.
  always_comb begin
    lane_a   = a_q[cnt*LANE_W +: LANE_W];
    lane_b   = b_q[cnt*LANE_W +: LANE_W];
    prod     = lane_a * lane_b;
    lane_a_x = {{(XLEN-LANE_W){lane_a[LANE_W-1]}}, lane_a};
    prod_x   = {{(XLEN-2*LANE_W){prod[2*LANE_W-1]}}, prod};
    if (pool_q) step = ($signed(lane_a_x) > $signed(acc)) ? lane_a_x : acc;
    else        step = acc + prod_x;

    done_entry            = pend_q;
    done_entry.alu_result = pend_jal ? pend_q.alu_result : step;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      pool_q      <= 1'b0;
      pend_jal    <= 1'b0;
      pend_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // Drain first; a load later in this block overrides it so the new entry replaces the old.
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_multi) begin
              a_q      <= bus.rs1_data;
              b_q      <= bus.rs2_data;
              pool_q   <= (bus.alu_ctrl == OP_MPOOL);
              acc      <= (bus.alu_ctrl == OP_MPOOL) ? lane0_x : '0;
              cnt      <= '0;
              pend_q   <= new_entry;
              pend_jal <= bus.jal;
              state    <= BUSY;
            end else begin
              out_q       <= new_entry;
              out_valid_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          acc <= step;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(NLANES-1)) begin
            out_q       <= done_entry;
            out_valid_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.alu_result    = out_q.alu_result;
  assign bus.store_data    = out_q.store_data;
  assign bus.branch_target = out_q.branch_target;
  assign bus.rd_idx_o      = out_q.rd_idx;
  assign bus.reg_write_o   = out_q.reg_write;
  assign bus.mem_read_o    = out_q.mem_read;
  assign bus.mem_write_o   = out_q.mem_write;
  assign bus.branch_taken  = out_q.branch_taken;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed corner cases then random traffic with random backpressure,
// checked by a queue-based scoreboard fed from a behavioural model.
module tb_ex_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_stage_if #(.XLEN(32)) bus ();

  ex_stage #(.XLEN(32), .LANE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic        use_imm;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, jal;
  } txn_t;

  typedef struct {
    logic [31:0] res, sd, tgt;
    logic [8:0]  ctl;  // {rd, reg_write, mem_read, mem_write, taken}
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input txn_t t);
    exp_t        e;
    logic [31:0] b, r;
    int          s;
    byte         x, y;
    b = t.use_imm ? t.imm : t.rs2;
    r = 32'd0;
    case (t.op)
      4'h0: r = t.rs1 + b;
      4'h1: r = t.rs1 - b;
      4'h2: r = t.rs1 & b;
      4'h3: r = t.rs1 | b;
      4'h4: r = t.rs1 ^ b;
      4'h8: r = ($signed(t.rs1) < 0) ? 32'd0 : t.rs1;
      4'h9: begin
        s = 0;
        for (int i = 0; i < 4; i++) begin
          x = t.rs1[8*i +: 8];
          y = t.rs2[8*i +: 8];
          s += int'(x) * int'(y);
        end
        r = s;
      end
      4'hA: for (int i = 0; i < 4; i++) r[8*i +: 8] = t.rs1[8*i +: 8] + t.rs2[8*i +: 8];
      4'hB: begin
        s = -1000;
        for (int i = 0; i < 4; i++) begin
          x = t.rs1[8*i +: 8];
          if (int'(x) > s) s = int'(x);
        end
        r = s;
      end
      default: r = 32'd0;
    endcase
    if (t.jal) r = t.pc + 32'd4;
    e.res = r;
    e.sd  = t.rs2;
    e.tgt = t.pc + t.imm;
    e.ctl = {t.rd, t.rw, t.mr, t.mw, t.jal || (t.br && t.rs1 == t.rs2)};
    return e;
  endfunction

  function automatic txn_t mk(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] imm, input logic use_imm);
    txn_t t;
    t.pc = 32'h1000; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm; t.use_imm = use_imm;
    t.op = op; t.rd = 5'd3; t.rw = 1'b1; t.mr = 1'b0; t.mw = 1'b0; t.br = 1'b0; t.jal = 1'b0;
    return t;
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the accept edge.
  task automatic send(input txn_t t, input bit force_res, input logic [31:0] res);
    exp_t e;
    bit   accepted;
    e = model(t);
    if (force_res) e.res = res;
    bus.pc = t.pc; bus.rs1_data = t.rs1; bus.rs2_data = t.rs2; bus.imm = t.imm;
    bus.use_imm = t.use_imm; bus.alu_ctrl = t.op; bus.rd_idx = t.rd;
    bus.reg_write = t.rw; bus.mem_read = t.mr; bus.mem_write = t.mw;
    bus.branch = t.br; bus.jal = t.jal;
    bus.in_valid = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 200 && !accepted; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(e);
        last_acc = cyc + 1;
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic check_lat(input int n);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (k < n) begin
        check("busy_out_valid", 32'(bus.out_valid), 32'd0);
        check("busy_in_ready", 32'(bus.in_ready), 32'd0);
      end else begin
        check("lat_out_valid", 32'(bus.out_valid), 32'd1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic peek_branch(input logic taken, input logic [31:0] tgt, input logic [31:0] res);
    @(negedge clk);
    check("branch_taken", 32'(bus.branch_taken), 32'(taken));
    if (taken) check("branch_target", bus.branch_target, tgt);
    check("jal_link", bus.alu_result, res);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every visible entry must match the queue head; pop on drain.
  always @(negedge clk) begin
    if (reset && bus.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got alu_result %h expected no entry", bus.alu_result);
      end else begin
        check("alu_result", bus.alu_result, sb[0].res);
        check("store_data", bus.store_data, sb[0].sd);
        check("branch_target_sb", bus.branch_target, sb[0].tgt);
        check("controls", 32'({bus.rd_idx_o, bus.reg_write_o, bus.mem_read_o, bus.mem_write_o,
                               bus.branch_taken}), 32'(sb[0].ctl));
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int   a1, rel, n;
    bit   done;

    reset = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.pc = '0; bus.rs1_data = '0; bus.rs2_data = '0; bus.imm = '0; bus.use_imm = 1'b0;
    bus.alu_ctrl = '0; bus.rd_idx = '0; bus.reg_write = 1'b0; bus.mem_read = 1'b0;
    bus.mem_write = 1'b0; bus.branch = 1'b0; bus.jal = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_alu_result", bus.alu_result, 32'd0);
    check("rst_branch_taken", 32'(bus.branch_taken), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;

    send(mk(4'h0, 32'd5, 32'd0, 32'hFFFF_FFFD, 1'b1), 1'b1, 32'd2);
    check_lat(0);
    send(mk(4'h1, 32'd5, 32'd7, 32'd0, 1'b0), 1'b1, 32'hFFFF_FFFE);
    check_lat(0);
    send(mk(4'h9, 32'h01FF_0203, 32'h0402_FF05, 32'hDEAD_BEEF, 1'b1), 1'b1, 32'h0000_000F);
    check_lat(4);
    send(mk(4'hB, 32'h807F_00FF, 32'd0, 32'd0, 1'b0), 1'b1, 32'h0000_007F);
    check_lat(4);

    send(mk(4'hA, 32'hFF01_7F80, 32'h0101_0180, 32'd0, 1'b0), 1'b1, 32'h0002_8000);
    a1 = last_acc;
    send(mk(4'h8, 32'h8000_0001, 32'd0, 32'd0, 1'b0), 1'b1, 32'd0);
    check("b2b_gap", 32'(last_acc - a1), 32'd1);
    @(posedge clk);
    #1;

    t = mk(4'h1, 32'd7, 32'd7, 32'h20, 1'b0); t.pc = 32'h100; t.br = 1'b1; t.rw = 1'b0;
    send(t, 1'b0, 32'd0);
    peek_branch(1'b1, 32'h120, 32'd0);
    t.rs2 = 32'd8;
    send(t, 1'b0, 32'd0);
    peek_branch(1'b0, 32'h0, 32'hFFFF_FFFF);
    t = mk(4'h0, 32'd1, 32'd2, 32'hFFFF_FFF8, 1'b0); t.pc = 32'h40; t.jal = 1'b1;
    send(t, 1'b0, 32'd0);
    peek_branch(1'b1, 32'h38, 32'h44);

    // Backpressure: hold the entry for five cycles while the next instruction waits.
    bus.out_ready = 1'b0;
    send(mk(4'h0, 32'd1, 32'd2, 32'd0, 1'b0), 1'b1, 32'd3);
    rel = 0;
    fork
      send(mk(4'h4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0), 1'b1, 32'hFF00_FF00);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", 32'(bus.in_ready), 32'd0);
          check("bp_hold", bus.alu_result, 32'd3);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        rel = cyc;
      end
    join
    check("drain_accept_edge", 32'(last_acc), 32'(rel + 1));
    @(negedge clk);
    check("bp_new_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Reset two edges into a MatMul discards it.
    send(mk(4'h9, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'd0, 1'b0), 1'b0, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    reset = 1'b1;
    @(negedge clk);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    send(mk(4'h0, 32'd10, 32'd20, 32'd0, 1'b0), 1'b1, 32'd30);
    check_lat(0);

    // Random traffic with random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          t.pc = $urandom; t.rs1 = $urandom;
          t.rs2 = ($urandom_range(0, 3) == 0) ? t.rs1 : $urandom;
          t.imm = $urandom; t.use_imm = 1'($urandom_range(0, 1));
          t.op = 4'($urandom_range(0, 15)); t.rd = 5'($urandom_range(0, 31));
          t.rw = 1'($urandom_range(0, 1)); t.mr = 1'($urandom_range(0, 1));
          t.mw = 1'($urandom_range(0, 1)); t.br = ($urandom_range(0, 3) == 0);
          t.jal = ($urandom_range(0, 7) == 0);
          send(t, 1'b0, 32'd0);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
